// File: rtl/alu_pkg.sv
// Shared ALU definitions: add/subtract opcodes, NZCV flag bit positions and
// the carry-seed rule that turns an opcode into the adder's initial carry.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_ADC = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Subtraction is A + ~B + seed, so SUB seeds 1 and SBC seeds CIN (1 = no borrow).
    function automatic logic carry_seed(input logic [1:0] op, input logic cin);
        logic seed;
        seed = 1'b0;
        case (op)
            OP_ADD:  seed = 1'b0;
            OP_ADC:  seed = cin;
            OP_SUB:  seed = 1'b1;
            default: seed = cin;
        endcase
        return seed;
    endfunction

    function automatic logic inverts_b(input logic [1:0] op);
        return (op == OP_SUB) || (op == OP_SBC);
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// One pipeline stage of the sliced adder: adds a CHUNK-bit slice with the
// carry from the previous stage and registers sum, carry-out and running zero.
module addsub_slice #(
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    input  logic             zin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             zero
);

    logic [CHUNK:0] total;
    logic           load;

    assign total    = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready;

    // zero accumulates: a slice is only "zero" if every slice below it was too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            zero      <= 1'b0;
        end else begin
            if (in_ready) begin
                out_valid <= in_valid;
            end
            if (load) begin
                sum  <= total[CHUNK-1:0];
                cout <= total[CHUNK];
                zero <= zin && (total[CHUNK-1:0] == '0);
            end
        end
    end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit add/subtract with NZCV flags, one CHUNK-bit carry slice
// per stage, valid/ready on both sides and one operation per cycle.
//
// Handshake: a beat moves across a boundary on a rising edge where both valid
// and ready are high; valid never depends on ready, ready may depend on the
// downstream ready (combinational chain from out_ready back to in_ready), and
// result/flags stay frozen while out_valid is high and out_ready is low.
module addsub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int STAGES = WIDTH / CHUNK;

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             seed;

    assign opa  = a;
    assign opb  = inverts_b(op) ? ~b : b;
    assign seed = carry_seed(op, cin);

    // src_a/src_b: operand bits not yet consumed by the beat entering stage k
    // (aligned with stage k-1). dsk: finished low result bits of the beat held
    // in stage k. Both shrink/grow by one chunk per stage.
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int SRCW = WIDTH - k * CHUNK;

        logic [SRCW-1:0]          src_a;
        logic [SRCW-1:0]          src_b;
        logic [(k+1)*CHUNK-1:0]   done;
        logic [CHUNK-1:0]         sum;
        logic                     vin;
        logic                     cin_k;
        logic                     zin_k;
        logic                     vld;
        logic                     rdy;
        logic                     rdy_next;
        logic                     ld;
        logic                     cry;
        logic                     zro;

        assign ld = vin && rdy;

        if (k == 0) begin : g_head
            assign src_a = opa;
            assign src_b = opb;
            assign vin   = in_valid;
            assign cin_k = seed;
            assign zin_k = 1'b1;
            assign done  = sum;
        end else begin : g_body
            logic [k*CHUNK-1:0] dsk;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    src_a <= '0;
                    src_b <= '0;
                    dsk   <= '0;
                end else begin
                    if (g_st[k-1].ld) begin
                        src_a <= g_st[k-1].src_a[SRCW+CHUNK-1:CHUNK];
                        src_b <= g_st[k-1].src_b[SRCW+CHUNK-1:CHUNK];
                    end
                    if (ld) begin
                        dsk <= g_st[k-1].done;
                    end
                end
            end

            assign vin   = g_st[k-1].vld;
            assign cin_k = g_st[k-1].cry;
            assign zin_k = g_st[k-1].zro;
            assign done  = {sum, dsk};
        end

        if (k == STAGES - 1) begin : g_tail
            assign rdy_next = out_ready;
        end else begin : g_mid
            assign rdy_next = g_st[k+1].rdy;
        end

        addsub_slice #(
            .CHUNK(CHUNK)
        ) u_slice (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (vin),
            .in_ready  (rdy),
            .out_valid (vld),
            .out_ready (rdy_next),
            .a         (src_a[CHUNK-1:0]),
            .b         (src_b[CHUNK-1:0]),
            .cin       (cin_k),
            .zin       (zin_k),
            .sum       (sum),
            .cout      (cry),
            .zero      (zro)
        );
    end

    // Operand sign bits of the beat in the last stage, needed for signed overflow.
    logic sign_a;
    logic sign_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_a <= 1'b0;
            sign_b <= 1'b0;
        end else if (g_st[STAGES-1].ld) begin
            sign_a <= g_st[STAGES-1].src_a[CHUNK-1];
            sign_b <= g_st[STAGES-1].src_b[CHUNK-1];
        end
    end

    logic [3:0] flags;

    assign result        = g_st[STAGES-1].done;
    assign flags[FLAG_N] = result[WIDTH-1];
    assign flags[FLAG_Z] = g_st[STAGES-1].zro;
    assign flags[FLAG_C] = g_st[STAGES-1].cry;
    assign flags[FLAG_V] = (sign_a == sign_b) && (result[WIDTH-1] != sign_a);

    assign flag_n    = flags[FLAG_N];
    assign flag_z    = flags[FLAG_Z];
    assign flag_c    = flags[FLAG_C];
    assign flag_v    = flags[FLAG_V];
    assign in_ready  = g_st[0].rdy;
    assign out_valid = g_st[STAGES-1].vld;

endmodule
